// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the row-stationary PE.
// Counter widths depend on module parameters, so they are derived through these functions.
package pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_FILL,
    ST_MAC,
    ST_ACC,
    ST_OUT,
    ST_SHIFT
  } pe_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned prod_width(input int unsigned data_bits);
    return 2 * data_bits;
  endfunction

  function automatic int unsigned NUM_WEIGHTS(input int unsigned num_filt,
                                              input int unsigned kernel_size);
    return num_filt * kernel_size;
  endfunction

  localparam int unsigned DEF_DATA_BITWIDTH = 16;
  localparam int unsigned DEF_KERNEL_SIZE   = 3;
  localparam int unsigned DEF_NUM_FILT      = 4;
  localparam int unsigned DEF_ACT_SIZE      = 5;
  localparam int unsigned DEF_PROD_WIDTH    = prod_width(DEF_DATA_BITWIDTH);
  localparam int unsigned DEF_TAP_WIDTH     = cnt_width(DEF_KERNEL_SIZE);
  localparam int unsigned DEF_FILT_WIDTH    = cnt_width(DEF_NUM_FILT);
  localparam int unsigned DEF_WIN_WIDTH     = cnt_width(DEF_ACT_SIZE - DEF_KERNEL_SIZE + 1);

endpackage

// File: rtl/pe_mac.sv
// Signed multiply-accumulate with a registered, wrapping accumulator.
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned PSUM_BITWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     add_psum,
  input  logic [DATA_BITWIDTH-1:0] a,
  input  logic [DATA_BITWIDTH-1:0] b,
  input  logic [PSUM_BITWIDTH-1:0] psum,
  output logic [PSUM_BITWIDTH-1:0] acc
);

  localparam int unsigned PROD_W = prod_width(DATA_BITWIDTH);

  logic signed [PROD_W-1:0]        prod;
  logic signed [PSUM_BITWIDTH-1:0] prod_ext;

  assign prod = $signed(a) * $signed(b);
  // Size cast sign-extends or truncates the full product to the psum width.
  assign prod_ext = PSUM_BITWIDTH'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clear ? prod_ext : acc + prod_ext;
    end else if (add_psum) begin
      acc <= acc + psum;
    end
  end

endmodule

// File: rtl/pe_rs_multi.sv
// Row-stationary PE: holds NUM_FILT filter rows, slides a window over one activation
// row and emits one psum per (window, filter), optionally added to an incoming psum.
module pe_rs_multi
  import pe_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned PSUM_BITWIDTH = 32,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned NUM_FILT      = 4,
  parameter int unsigned ACT_SIZE      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_psum_acc,
  input  logic                     start,
  input  logic                     wght_valid,
  output logic                     wght_ready,
  input  logic [DATA_BITWIDTH-1:0] wght_data,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [DATA_BITWIDTH-1:0] act_data,
  input  logic                     psum_in_valid,
  output logic                     psum_in_ready,
  input  logic [PSUM_BITWIDTH-1:0] psum_in_data,
  output logic                     psum_out_valid,
  input  logic                     psum_out_ready,
  output logic [PSUM_BITWIDTH-1:0] psum_out_data,
  output logic                     busy,
  output logic                     load_done,
  output logic                     compute_done
);

  localparam int unsigned NW   = NUM_WEIGHTS(NUM_FILT, KERNEL_SIZE);
  localparam int unsigned NWIN = ACT_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned WIW  = cnt_width(NW);
  localparam int unsigned KW   = cnt_width(KERNEL_SIZE);
  localparam int unsigned FW   = cnt_width(NUM_FILT);
  localparam int unsigned NWW  = cnt_width(NWIN);

  pe_state_t state, state_next;

  logic                     wghts_loaded;
  logic                     psum_acc_en;
  logic [DATA_BITWIDTH-1:0] wght_mem [NW];
  logic [DATA_BITWIDTH-1:0] win      [KERNEL_SIZE];
  logic [WIW-1:0]           wr_idx;
  logic [WIW-1:0]           rd_idx;
  logic [KW-1:0]            fill_cnt;
  logic [KW-1:0]            tap;
  logic [FW-1:0]            filt;
  logic [NWW-1:0]           win_idx;

  logic mac_clear, mac_en, mac_add;
  logic last_wght, last_fill, last_tap, last_filt, last_win;

  assign last_wght = (wr_idx   == WIW'(NW - 1));
  assign last_fill = (fill_cnt == KW'(KERNEL_SIZE - 1));
  assign last_tap  = (tap      == KW'(KERNEL_SIZE - 1));
  assign last_filt = (filt     == FW'(NUM_FILT - 1));
  assign last_win  = (win_idx  == NWW'(NWIN - 1));

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_next     = state;
    wght_ready     = 1'b0;
    act_ready      = 1'b0;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    mac_clear      = 1'b0;
    mac_en         = 1'b0;
    mac_add        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (wght_valid)                 state_next = ST_LOAD_W;
        else if (start && wghts_loaded) state_next = ST_FILL;
      end
      ST_LOAD_W: begin
        wght_ready = 1'b1;
        if (wght_valid && last_wght) state_next = ST_IDLE;
      end
      ST_FILL: begin
        act_ready = 1'b1;
        if (act_valid && last_fill) state_next = ST_MAC;
      end
      ST_MAC: begin
        mac_en    = 1'b1;
        mac_clear = (tap == '0);
        if (last_tap) state_next = ST_ACC;
      end
      ST_ACC: begin
        if (psum_acc_en) begin
          psum_in_ready = 1'b1;
          if (psum_in_valid) begin
            mac_add    = 1'b1;
            state_next = ST_OUT;
          end
        end else begin
          state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) begin
          if (!last_filt)     state_next = ST_MAC;
          else if (!last_win) state_next = ST_SHIFT;
          else                state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        act_ready = 1'b1;
        if (act_valid) state_next = ST_MAC;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // rd_idx walks f*KERNEL_SIZE+k linearly across all filters of one window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      wghts_loaded <= 1'b0;
      psum_acc_en  <= 1'b0;
      load_done    <= 1'b0;
      compute_done <= 1'b0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      fill_cnt     <= '0;
      tap          <= '0;
      filt         <= '0;
      win_idx      <= '0;
    end else begin
      state        <= state_next;
      load_done    <= 1'b0;
      compute_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (wght_valid) begin
            wr_idx <= '0;
          end else if (start && wghts_loaded) begin
            psum_acc_en <= cfg_psum_acc;
            fill_cnt    <= '0;
            win_idx     <= '0;
          end
        end
        ST_LOAD_W: begin
          if (wght_valid) begin
            if (last_wght) begin
              wr_idx       <= '0;
              load_done    <= 1'b1;
              wghts_loaded <= 1'b1;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (act_valid) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (last_fill) begin
              tap    <= '0;
              filt   <= '0;
              rd_idx <= '0;
            end
          end
        end
        ST_MAC: begin
          rd_idx <= rd_idx + 1'b1;
          tap    <= last_tap ? '0 : tap + 1'b1;
        end
        ST_OUT: begin
          if (psum_out_ready) begin
            if (!last_filt)    filt <= filt + 1'b1;
            else if (last_win) compute_done <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (act_valid) begin
            win_idx <= win_idx + 1'b1;
            filt    <= '0;
            tap     <= '0;
            rd_idx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wght_ready && wght_valid) wght_mem[wr_idx] <= wght_data;
    if (act_ready && act_valid) begin
      for (int unsigned i = 0; i + 1 < KERNEL_SIZE; i++) win[i] <= win[i+1];
      win[KERNEL_SIZE-1] <= act_data;
    end
  end

  pe_mac #(
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .PSUM_BITWIDTH(PSUM_BITWIDTH)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (mac_clear),
    .en       (mac_en),
    .add_psum (mac_add),
    .a        (wght_mem[rd_idx]),
    .b        (win[tap]),
    .psum     (psum_in_data),
    .acc      (psum_out_data)
  );

endmodule

// File: tb/tb_pe_rs_multi.sv
// Self-checking bench for pe_rs_multi: directed rows plus randomized rows with handshake
// gaps, all checked against a convolution model computed with plain integer arithmetic.
module tb_pe_rs_multi;

  localparam int unsigned DW   = 16;
  localparam int unsigned PW   = 32;
  localparam int unsigned K    = 3;
  localparam int unsigned NF   = 2;
  localparam int unsigned AS   = 5;
  localparam int unsigned NWIN = AS - K + 1;
  localparam int unsigned NOUT = NWIN * NF;
  localparam int unsigned NW   = NF * K;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_psum_acc = 1'b0;
  logic          start = 1'b0;
  logic          wght_valid = 1'b0;
  logic          wght_ready;
  logic [DW-1:0] wght_data = '0;
  logic          act_valid = 1'b0;
  logic          act_ready;
  logic [DW-1:0] act_data = '0;
  logic          psum_in_valid = 1'b0;
  logic          psum_in_ready;
  logic [PW-1:0] psum_in_data = '0;
  logic          psum_out_valid;
  logic          psum_out_ready = 1'b0;
  logic [PW-1:0] psum_out_data;
  logic          busy, load_done, compute_done;

  pe_rs_multi #(
    .DATA_BITWIDTH(DW),
    .PSUM_BITWIDTH(PW),
    .KERNEL_SIZE  (K),
    .NUM_FILT     (NF),
    .ACT_SIZE     (AS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_psum_acc   (cfg_psum_acc),
    .start          (start),
    .wght_valid     (wght_valid),
    .wght_ready     (wght_ready),
    .wght_data      (wght_data),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .act_data       (act_data),
    .psum_in_valid  (psum_in_valid),
    .psum_in_ready  (psum_in_ready),
    .psum_in_data   (psum_in_data),
    .psum_out_valid (psum_out_valid),
    .psum_out_ready (psum_out_ready),
    .psum_out_data  (psum_out_data),
    .busy           (busy),
    .load_done      (load_done),
    .compute_done   (compute_done)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned failed = 0;

  logic signed [DW-1:0] wt   [NF][K];
  logic signed [DW-1:0] acts [AS];
  logic        [PW-1:0] pin  [NOUT];
  logic        [PW-1:0] expv [NOUT];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    total++;
    assert (obs === expd) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Reference: each output is the dot product of a filter row with a K-wide slice of the row.
  task automatic build_expect(input bit cfg);
    longint s;
    for (int unsigned w = 0; w < NWIN; w++) begin
      for (int unsigned f = 0; f < NF; f++) begin
        s = 0;
        for (int unsigned k = 0; k < K; k++) s += longint'(wt[f][k]) * longint'(acts[w+k]);
        if (cfg) s += longint'(pin[w*NF+f]);
        expv[w*NF+f] = s[PW-1:0];
      end
    end
  endtask

  task automatic load_weights(input bit with_start);
    int unsigned i = 0;
    int unsigned cyc = 0;
    bit hs;
    wght_valid = 1'b1;
    start = with_start;
    while (i < NW && cyc < 100) begin
      wght_data = wt[i/K][i%K];
      hs = wght_ready;
      @(negedge clk);
      cyc++;
      if (with_start && cyc == 1) begin
        start = 1'b0;
        chk("start_wght_busy", busy, 1);
        chk("start_wght_ready", wght_ready, 1);
        chk("start_wght_act_ready", act_ready, 0);
      end
      if (hs) i++;
    end
    wght_valid = 1'b0;
    chk("load_count", i, NW);
    chk("load_done", load_done, 1);
    chk("load_idle", busy, 0);
    @(negedge clk);
    chk("load_done_pulse", load_done, 0);
  endtask

  task automatic run_row(input bit cfg, input int unsigned pin_stall,
                         input int unsigned out_stall, input bit rnd, input bit abort);
    int unsigned ai = 0, pi = 0, oi = 0, cyc = 0, pin_seen = 0, out_seen = 0;
    bit a_hs, p_hs, o_hs;
    build_expect(cfg);
    cfg_psum_acc = cfg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_psum_acc = 1'b0;
    chk("start_busy", busy, 1);
    while (oi < NOUT && cyc < 3000) begin
      act_valid      = (ai < AS) && (!rnd || $urandom_range(0, 2) != 0);
      act_data       = (ai < AS) ? acts[ai] : '0;
      psum_in_valid  = (pi < NOUT) && (pin_seen >= pin_stall) && (!rnd || $urandom_range(0, 2) != 0);
      psum_in_data   = (pi < NOUT) ? pin[pi] : '0;
      psum_out_ready = (out_seen >= out_stall) && (!rnd || $urandom_range(0, 2) != 0);
      a_hs = act_valid && act_ready;
      p_hs = psum_in_valid && psum_in_ready;
      o_hs = psum_out_valid && psum_out_ready;
      if (!cfg) chk("psum_in_ready_off", psum_in_ready, 0);
      if (psum_in_ready) begin
        pin_seen++;
        if (!psum_in_valid) chk("stall_out_valid", psum_out_valid, 0);
      end
      if (psum_out_valid) begin
        chk(o_hs ? "psum_out" : "psum_hold", psum_out_data, expv[oi]);
        if (!psum_out_ready) chk("stall_act_ready", act_ready, 0);
        out_seen++;
      end
      @(negedge clk);
      cyc++;
      if (a_hs) ai++;
      if (p_hs) pi++;
      if (o_hs) oi++;
      if (abort && oi == NF && ai == K + 1) break;
    end
    act_valid = 1'b0;
    psum_in_valid = 1'b0;
    psum_out_ready = 1'b0;
    if (abort) begin
      // Window 1 is now in its first MAC cycle.
      chk("abort_reached", ai, K + 1);
      reset = 1'b0;
      #1;
      chk("rst_psum_out_data", psum_out_data, 0);
      chk("rst_psum_out_valid", psum_out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_act_ready", act_ready, 0);
      @(negedge clk);
      reset = 1'b1;
    end else begin
      chk("row_outputs", oi, NOUT);
      chk("row_acts", ai, AS);
      if (cfg) chk("row_psum_in", pi, NOUT);
      chk("compute_done", compute_done, 1);
      chk("row_idle", busy, 0);
      @(negedge clk);
      chk("compute_done_pulse", compute_done, 0);
      chk("no_extra_out", psum_out_valid, 0);
    end
  endtask

  task automatic set_directed();
    wt[0][0] = 1;  wt[0][1] = 2; wt[0][2] = 3;
    wt[1][0] = -1; wt[1][1] = 0; wt[1][2] = 1;
    for (int unsigned i = 0; i < AS; i++) acts[i] = DW'(i + 1);
    for (int unsigned i = 0; i < NOUT; i++) pin[i] = 100;
  endtask

  task automatic check_start_ignored(input string tag);
    start = 1'b1;
    act_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_act_ready"}, act_ready, 0);
      @(negedge clk);
    end
    act_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_wght_ready0", wght_ready, 0);
    chk("rst_act_ready0", act_ready, 0);
    chk("rst_psum_in_ready0", psum_in_ready, 0);
    chk("rst_psum_out_valid0", psum_out_valid, 0);
    chk("rst_load_done0", load_done, 0);
    chk("rst_compute_done0", compute_done, 0);
    chk("rst_psum_out_data0", psum_out_data, 0);
    reset = 1'b1;
    @(negedge clk);

    check_start_ignored("noweights");

    set_directed();
    load_weights(1'b1);
    run_row(1'b0, 0, 0, 1'b0, 1'b0);
    chk("dir_exp_first", expv[0], 14);
    run_row(1'b1, 5, 0, 1'b0, 1'b0);
    run_row(1'b0, 0, 10, 1'b0, 1'b0);

    for (int unsigned f = 0; f < NF; f++)
      for (int unsigned k = 0; k < K; k++) wt[f][k] = 16'h8000;
    for (int unsigned i = 0; i < AS; i++) acts[i] = 16'h8000;
    load_weights(1'b0);
    run_row(1'b0, 0, 0, 1'b0, 1'b0);
    chk("wrap_exp", expv[0], 32'hC000_0000);

    for (int unsigned r = 0; r < 6; r++) begin
      for (int unsigned f = 0; f < NF; f++)
        for (int unsigned k = 0; k < K; k++) wt[f][k] = DW'($urandom);
      for (int unsigned i = 0; i < AS; i++) acts[i] = DW'($urandom);
      for (int unsigned i = 0; i < NOUT; i++) pin[i] = $urandom;
      load_weights(1'b0);
      run_row(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    set_directed();
    load_weights(1'b0);
    run_row(1'b0, 0, 0, 1'b0, 1'b1);
    check_start_ignored("after_reset");
    load_weights(1'b0);
    run_row(1'b1, 0, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pe_rs_multi.md
Name: pe_rs_multi

Overview:
- Parametrised row-stationary processing element for 1-D row convolution.
- Holds NUM_FILT filter rows of KERNEL_SIZE taps each, and streams one activation row through a sliding window.
- For every window position and every filter, emits one partial sum, optionally added to an incoming partial sum from a neighbouring PE.
- Sits between the global-buffer feeders and the vertical psum chain of a PE array; all data movement uses valid/ready handshakes.

Parameters:
DATA_BITWIDTH, 16, signed width of weights and activations
PSUM_BITWIDTH, 32, signed width of partial sums and the accumulator
KERNEL_SIZE, 3, taps per filter row (at least 1)
NUM_FILT, 4, filter rows held at once (at least 1)
ACT_SIZE, 5, activation row length (at least KERNEL_SIZE)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_psum_acc  in  1  1 = add psum_in to each result; sampled on accepted start
start  in  1  begin a row computation (single-cycle pulse, honoured only in IDLE)
wght_valid / wght_ready / wght_data  in / out / DATA_BITWIDTH  weight load stream
act_valid / act_ready / act_data  in / out / DATA_BITWIDTH  activation stream
psum_in_valid / psum_in_ready / psum_in_data  in / out / PSUM_BITWIDTH  incoming psum stream
psum_out_valid / psum_out_ready / psum_out_data  out / in / PSUM_BITWIDTH  outgoing psum stream
busy  out  1  high in every state except IDLE
load_done  out  1  one-cycle pulse after the last weight is accepted
compute_done  out  1  one-cycle pulse after the last psum_out handshake of a row

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all ready, valid and pulse outputs are 0; psum_out_data is 0.
  - The internal wghts_loaded flag is cleared. Weight storage contents are don't-care.
  - A reset mid-operation abandons the row; no partial output follows.
- States: IDLE, LOAD_W, FILL, MAC, ACC, OUT, SHIFT.
- IDLE:
  - wght_valid=1 → LOAD_W.
  - Otherwise, start=1 with wghts_loaded=1 → FILL, latching cfg_psum_acc.
  - start with wghts_loaded=0 is ignored.
  - If start and wght_valid arrive in the same cycle, LOAD_W wins.
- LOAD_W:
  - wght_ready=1. Accepts NUM_FILT*KERNEL_SIZE words in filter-major order: index f*KERNEL_SIZE+k.
  - The cycle after the last transfer: load_done=1, wghts_loaded=1, state → IDLE.
  - Reloading overwrites all taps.
- FILL: act_ready=1; shifts KERNEL_SIZE activations into the window win[0..K-1], oldest at win[0], then → MAC with filter f=0.
- MAC:
  - Exactly KERNEL_SIZE cycles, one tap per cycle: acc = sum over k of w[f][k]*win[k].
  - The product is full 2*DATA_BITWIDTH signed, sign-extended or truncated to PSUM_BITWIDTH.
  - Accumulation wraps modulo 2^PSUM_BITWIDTH; no saturation.
  - The accumulator clears at the start of each filter.
- ACC:
  - If the latched cfg_psum_acc is 1: psum_in_ready=1 until one transfer, and acc += psum_in_data (wrapping). This stalls indefinitely while psum_in_valid=0.
  - If the latched cfg_psum_acc is 0: one cycle, with psum_in_ready held 0.
- OUT:
  - psum_out_valid=1 with psum_out_data=acc, held stable until transfer.
  - After transfer:
    - If f < NUM_FILT-1: f+1, → MAC.
    - Else, if windows produced < ACT_SIZE-KERNEL_SIZE+1: → SHIFT.
    - Else: compute_done=1 for one cycle, → IDLE.
- SHIFT: act_ready=1 until one transfer; the window shifts by one; f=0; → MAC.
- act_ready is 0 outside FILL and SHIFT; wght_ready is 0 outside LOAD_W. Extra input activity is ignored, not buffered.
- Output order per row: window 0 filters 0..NUM_FILT-1, window 1 filters 0..NUM_FILT-1, and so on.
- Minimum latency per output is KERNEL_SIZE+2 cycles (MAC, ACC, OUT) with no stalls.

Decomposition:
- Package pe_pkg holds:
  - the state enum typedef;
  - localparams for product width and counter widths ($clog2 of NUM_FILT, KERNEL_SIZE, ACT_SIZE-KERNEL_SIZE+1);
  - the NUM_WEIGHTS constant function.
- One sub-module, pe_mac:
  - signed multiply-accumulate with a registered accumulator;
  - inputs clear, en, add_psum.

Test Plan:
1. K=3, NUM_FILT=2, ACT_SIZE=5, filter 0={1,2,3}, filter 1={-1,0,1}, acts {1,2,3,4,5}, cfg_psum_acc=0 → psum_out sequence 14,2,20,2,26,2, then one compute_done pulse.
2. Same as 1 with cfg_psum_acc=1 and psum_in=100 each, psum_in_valid held 0 for 5 cycles before the first transfer → outputs 114,102,120,102,126,102; psum_out_valid stays 0 during the stall.
3. Same as 1 with psum_out_ready=0 for 10 cycles at the first output → psum_out_data stays 14 and stable, act_ready=0, no further outputs until ready rises.
4. Weights and activations all 0x8000 with K=3 → acc=3*2^30, wraps to 0xC0000000 on psum_out_data.
5. reset=0 during window 1's MAC → outputs immediately 0, IDLE; a subsequent start produces no act_ready until weights are reloaded and load_done pulses.
6. start with no weights loaded → ignored: busy=0, act_ready=0; start coincident with wght_valid → enters LOAD_W.
